// File: rtl/rgb_to_yuv_pkg.sv
// Shared types and constants for the RGB to YUV frame converter.
package rgb_to_yuv_pkg;

  typedef enum logic [3:0] {
    S_IDLE, S_RD0, S_RD1, S_RD2, S_RD3,
    S_CV0, S_CV1, S_WY, S_WU, S_WV, S_FIN
  } state_e;

  localparam int AW     = 18;
  localparam int DW     = 16;
  localparam int FRAC_W = 16;

  // Conversion coefficients, 16-bit fraction
  localparam int C_YR = 16829;
  localparam int C_YG = 33039;
  localparam int C_YB = 6416;
  localparam int C_UR = -9714;
  localparam int C_UG = -19070;
  localparam int C_UB = 28784;
  localparam int C_VR = 28784;
  localparam int C_VG = -24103;
  localparam int C_VB = -4681;

  localparam int OFS_Y = 16;
  localparam int OFS_C = 128;

  // Saturate a signed result into an 8-bit code
  function automatic logic [7:0] clamp8(input int v);
    if (v < 0)        return 8'd0;
    else if (v > 255) return 8'd255;
    else              return 8'(v);
  endfunction

endpackage

// File: rtl/rgb_to_yuv_pixel.sv
// Combinational one-pixel RGB -> YUV conversion with clamping.
module rgb_to_yuv_pixel
  import rgb_to_yuv_pkg::*;
(
  input  logic [7:0] r,
  input  logic [7:0] g,
  input  logic [7:0] b,
  output logic [7:0] y,
  output logic [7:0] u,
  output logic [7:0] v
);

  int ri, gi, bi, ys, us, vs;

  // Signed fixed-point dot products, floor shift, offset, then clamp
  always_comb begin
    ri = int'({24'd0, r});
    gi = int'({24'd0, g});
    bi = int'({24'd0, b});
    ys = ((C_YR * ri + C_YG * gi + C_YB * bi) >>> FRAC_W) + OFS_Y;
    us = ((C_UR * ri + C_UG * gi + C_UB * bi) >>> FRAC_W) + OFS_C;
    vs = ((C_VR * ri + C_VG * gi + C_VB * bi) >>> FRAC_W) + OFS_C;
    y  = clamp8(ys);
    u  = clamp8(us);
    v  = clamp8(vs);
  end

endmodule

// File: rtl/rgb_to_yuv.sv
// Frame converter: reads packed RGB pixel pairs, writes planar Y/U/V words.
module rgb_to_yuv
  import rgb_to_yuv_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [15:0]   width,
  input  logic [15:0]   height,
  output logic          rd_en,
  output logic [AW-1:0] r_addr,
  input  logic [DW-1:0] r_data,
  output logic          wr_en,
  output logic [AW-1:0] w_addr,
  output logic [DW-1:0] wdata,
  output logic          busy,
  output logic          done
);

  state_e      state_q, state_d;
  logic [15:0] w_q, w_d, h_q, h_d;
  logic [15:0] k_q, k_d;
  logic [15:0] w0_q, w0_d, w1_q, w1_d, w2_q, w2_d;
  logic [15:0] y_q, y_d, u_q, u_d, v_q, v_d;

  // Frame geometry derived from the latched size; W*H fits 17 bits
  logic [16:0]   wh, start_wh;
  logic [AW-1:0] rb, u_base, v_base, rd_base, k_ext;
  logic [15:0]   last_k;

  assign wh       = 17'(w_q * h_q);
  assign start_wh = 17'(width * height);
  assign u_base   = 18'(wh >> 1);
  assign v_base   = 18'(wh);
  assign rb       = v_base + u_base;
  assign last_k   = 16'((wh >> 1) - 17'd1);
  assign k_ext    = 18'(k_q);
  assign rd_base  = rb + k_ext + {k_ext[AW-2:0], 1'b0};

  // Single pixel datapath, shared between the two halves of a pair
  logic [7:0] pr, pg, pb, py, pu, pv;

  always_comb begin
    if (state_q == S_CV1) begin
      pr = w1_q[7:0];
      pg = w2_q[15:8];
      pb = w2_q[7:0];
    end else begin
      pr = w0_q[15:8];
      pg = w0_q[7:0];
      pb = w1_q[15:8];
    end
  end

  rgb_to_yuv_pixel u_pix (
    .r (pr), .g (pg), .b (pb),
    .y (py), .u (pu), .v (pv)
  );

  // Next-state, datapath updates and memory strobes
  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    h_d     = h_q;
    k_d     = k_q;
    w0_d    = w0_q;
    w1_d    = w1_q;
    w2_d    = w2_q;
    y_d     = y_q;
    u_d     = u_q;
    v_d     = v_q;
    rd_en   = 1'b0;
    r_addr  = '0;
    wr_en   = 1'b0;
    w_addr  = '0;
    wdata   = '0;
    busy    = (state_q != S_IDLE);
    done    = 1'b0;
    case (state_q)
      S_IDLE: if (start) begin
        w_d     = width;
        h_d     = height;
        k_d     = '0;
        state_d = (start_wh == 17'd0) ? S_FIN : S_RD0;
      end
      S_RD0: begin
        rd_en   = 1'b1;
        r_addr  = rd_base;
        state_d = S_RD1;
      end
      S_RD1: begin
        rd_en   = 1'b1;
        r_addr  = rd_base + 18'd1;
        w0_d    = r_data;
        state_d = S_RD2;
      end
      S_RD2: begin
        rd_en   = 1'b1;
        r_addr  = rd_base + 18'd2;
        w1_d    = r_data;
        state_d = S_RD3;
      end
      S_RD3: begin
        w2_d    = r_data;
        state_d = S_CV0;
      end
      S_CV0: begin
        y_d     = {py, y_q[7:0]};
        u_d     = {pu, u_q[7:0]};
        v_d     = {pv, v_q[7:0]};
        state_d = S_CV1;
      end
      S_CV1: begin
        y_d     = {y_q[15:8], py};
        u_d     = {u_q[15:8], pu};
        v_d     = {v_q[15:8], pv};
        state_d = S_WY;
      end
      S_WY: begin
        wr_en   = 1'b1;
        w_addr  = k_ext;
        wdata   = y_q;
        state_d = S_WU;
      end
      S_WU: begin
        wr_en   = 1'b1;
        w_addr  = u_base + k_ext;
        wdata   = u_q;
        state_d = S_WV;
      end
      S_WV: begin
        wr_en  = 1'b1;
        w_addr = v_base + k_ext;
        wdata  = v_q;
        if (k_q == last_k) begin
          state_d = S_FIN;
        end else begin
          k_d     = k_q + 16'd1;
          state_d = S_RD0;
        end
      end
      S_FIN: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers, synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      w_q     <= '0;
      h_q     <= '0;
      k_q     <= '0;
      w0_q    <= '0;
      w1_q    <= '0;
      w2_q    <= '0;
      y_q     <= '0;
      u_q     <= '0;
      v_q     <= '0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      h_q     <= h_d;
      k_q     <= k_d;
      w0_q    <= w0_d;
      w1_q    <= w1_d;
      w2_q    <= w2_d;
      y_q     <= y_d;
      u_q     <= u_d;
      v_q     <= v_d;
    end
  end

endmodule

// File: tb/tb_rgb_to_yuv.sv
// Directed bench for rgb_to_yuv with a behavioural word memory.
module tb_rgb_to_yuv;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] width, height;
  logic        rd_en, wr_en, busy, done;
  logic [17:0] r_addr, w_addr;
  logic [15:0] r_data, wdata;

  rgb_to_yuv dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .width  (width),
    .height (height),
    .rd_en  (rd_en),
    .r_addr (r_addr),
    .r_data (r_data),
    .wr_en  (wr_en),
    .w_addr (w_addr),
    .wdata  (wdata),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [0:262143];

  // Read data returned one cycle after the strobe
  always @(posedge clk) begin
    if (rd_en) r_data <= mem[r_addr];
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Frame run bookkeeping
  logic [33:0] wlog[$];
  int done_cyc, nrd, nwr;
  bit conflict, busy_bad;

  task automatic do_frame(input logic [15:0] w, input logic [15:0] h,
                          input int hold, input int max_cyc);
    @(negedge clk);
    width = w; height = h; start = 1'b1;
    wlog.delete();
    done_cyc = -1; nrd = 0; nwr = 0; conflict = 0; busy_bad = 0;
    for (int i = 1; i <= max_cyc; i++) begin
      @(negedge clk);
      if (rd_en) nrd++;
      if (wr_en) begin nwr++; wlog.push_back({w_addr, wdata}); end
      if (rd_en && wr_en) conflict = 1;
      if (!busy) busy_bad = 1;
      if (i >= hold) start = 1'b0;
      if (i == 3) begin width = 16'd99; height = 16'd7; end
      if (done) begin done_cyc = i; break; end
    end
    start = 1'b0;
  endtask

  // Independent reference using real-valued floor
  function automatic int lim(input int x);
    return (x < 0) ? 0 : (x > 255) ? 255 : x;
  endfunction

  function automatic logic [23:0] ref_yuv(input int r, input int g, input int b);
    int yi, ui, vi;
    yi = int'($floor((16829.0*r + 33039.0*g + 6416.0*b) / 65536.0)) + 16;
    ui = int'($floor((-9714.0*r - 19070.0*g + 28784.0*b) / 65536.0)) + 128;
    vi = int'($floor((28784.0*r - 24103.0*g - 4681.0*b) / 65536.0)) + 128;
    return {8'(lim(yi)), 8'(lim(ui)), 8'(lim(vi))};
  endfunction

  int pr[8], pg[8], pb[8];
  logic [23:0] e0, e1;
  logic [33:0] wv;

  initial begin
    rst = 1'b1; start = 1'b0; width = '0; height = '0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {busy, done, rd_en, wr_en, r_addr, w_addr, wdata}, 64'd0);
    rst = 1'b0;

    // Black + white pair
    mem[3] = 16'h0000; mem[4] = 16'h00FF; mem[5] = 16'hFFFF;
    do_frame(16'd2, 16'd1, 1, 40);
    chk("bw_done_cycle", done_cyc, 10);
    chk("bw_reads", nrd, 3);
    chk("bw_writes", nwr, 3);
    chk("bw_y", wlog[0], {18'd0, 16'h10EB});
    chk("bw_u", wlog[1], {18'd1, 16'h8080});
    chk("bw_v", wlog[2], {18'd2, 16'h8080});
    chk("bw_no_conflict", conflict, 0);
    chk("bw_busy", busy_bad, 0);
    @(negedge clk);
    chk("bw_idle_after", {busy, done}, 2'b00);

    // Two red pixels
    mem[3] = 16'hFF00; mem[4] = 16'h00FF; mem[5] = 16'h0000;
    do_frame(16'd2, 16'd1, 1, 40);
    chk("red_done_cycle", done_cyc, 10);
    chk("red_y", wlog[0], {18'd0, 16'h5151});
    chk("red_u", wlog[1], {18'd1, 16'h5A5A});
    chk("red_v", wlog[2], {18'd2, 16'hEFEF});

    // Start held high through a frame, then one more pulse
    do_frame(16'd2, 16'd1, 100, 40);
    chk("hold_done_cycle", done_cyc, 10);
    chk("hold_writes", nwr, 3);
    chk("hold_y", wlog[0], {18'd0, 16'h5151});
    begin
      int extra = 0;
      for (int i = 0; i < 12; i++) begin
        @(negedge clk);
        if (busy || done || rd_en || wr_en) extra++;
      end
      chk("hold_no_restart", extra, 0);
    end
    do_frame(16'd2, 16'd1, 1, 40);
    chk("pulse_done_cycle", done_cyc, 10);
    chk("pulse_writes", nwr, 3);

    // Zero-size frame
    do_frame(16'd0, 16'd5, 1, 40);
    chk("zero_done_cycle", done_cyc, 1);
    chk("zero_reads", nrd, 0);
    chk("zero_writes", nwr, 0);
    @(negedge clk);
    chk("zero_idle_after", {busy, done}, 2'b00);

    // 4x2 frame data at base 12
    for (int p = 0; p < 8; p++) begin
      pr[p] = $urandom_range(0, 255);
      pg[p] = $urandom_range(0, 255);
      pb[p] = $urandom_range(0, 255);
    end
    pr[0] = 255; pg[0] = 0;   pb[0] = 255;
    pr[1] = 0;   pg[1] = 255; pb[1] = 0;
    for (int k = 0; k < 4; k++) begin
      mem[12 + 3*k]     = {8'(pr[2*k]), 8'(pg[2*k])};
      mem[12 + 3*k + 1] = {8'(pb[2*k]), 8'(pr[2*k+1])};
      mem[12 + 3*k + 2] = {8'(pg[2*k+1]), 8'(pb[2*k+1])};
    end

    // Reset in cycle 5 of a 4-pair frame
    @(negedge clk);
    width = 16'd4; height = 16'd2; start = 1'b1;
    nwr = 0;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (wr_en) nwr++;
    end
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_outputs", {busy, done, rd_en, wr_en, r_addr, w_addr, wdata}, 64'd0);
    chk("rst_mid_no_writes", nwr, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_idle", {busy, done}, 2'b00);

    // Fresh full frame after the reset
    do_frame(16'd4, 16'd2, 1, 100);
    chk("f4_done_cycle", done_cyc, 37);
    chk("f4_reads", nrd, 12);
    chk("f4_writes", nwr, 12);
    chk("f4_no_conflict", conflict, 0);
    chk("f4_busy", busy_bad, 0);
    for (int k = 0; k < 4; k++) begin
      e0 = ref_yuv(pr[2*k], pg[2*k], pb[2*k]);
      e1 = ref_yuv(pr[2*k+1], pg[2*k+1], pb[2*k+1]);
      wv = (wlog.size() > 3*k)   ? wlog[3*k]   : 34'h3FFFFFFFF;
      chk($sformatf("f4_y%0d", k), wv, {18'(k),     e0[23:16], e1[23:16]});
      wv = (wlog.size() > 3*k+1) ? wlog[3*k+1] : 34'h3FFFFFFFF;
      chk($sformatf("f4_u%0d", k), wv, {18'(4 + k), e0[15:8],  e1[15:8]});
      wv = (wlog.size() > 3*k+2) ? wlog[3*k+2] : 34'h3FFFFFFFF;
      chk($sformatf("f4_v%0d", k), wv, {18'(8 + k), e0[7:0],   e1[7:0]});
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
